// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command one-hot indices, condition codes, NOP encoding,
// fetch FSM states and the instruction-class decoder used by the fetch/decode stage.
package cpu_pkg;

  localparam int CMD_W = 64;

  localparam logic [5:0] CMD_DP    = 6'd0;
  localparam logic [5:0] CMD_BX    = 6'd1;
  localparam logic [5:0] CMD_B     = 6'd2;
  localparam logic [5:0] CMD_BL    = 6'd3;
  localparam logic [5:0] CMD_LDR0  = 6'd4;
  localparam logic [5:0] CMD_LDR1  = 6'd5;
  localparam logic [5:0] CMD_STR0  = 6'd6;
  localparam logic [5:0] CMD_STR1  = 6'd7;
  localparam logic [5:0] CMD_SWP   = 6'd8;
  localparam logic [5:0] CMD_UNDEF = 6'd63;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_VALID = 2'd2
  } fetch_state_e;

  // Priority matters: BX and SWP live inside the DP encoding space and must win.
  // Register-offset transfers with bit4 set are media/undefined encodings.
  function automatic logic [CMD_W-1:0] decode_cmd(input logic [31:0] w);
    logic [CMD_W-1:0] c;
    c = '0;
    if (w[27:4] == 24'h12FFF1)
      c[CMD_BX] = 1'b1;
    else if (w[27:25] == 3'b101)
      c[w[24] ? CMD_BL : CMD_B] = 1'b1;
    else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'h09)
      c[CMD_SWP] = 1'b1;
    else if (w[27:26] == 2'b01) begin
      if (w[25] && w[4])
        c[CMD_UNDEF] = 1'b1;
      else if (w[20])
        c[w[25] ? CMD_LDR1 : CMD_LDR0] = 1'b1;
      else
        c[w[25] ? CMD_STR1 : CMD_STR0] = 1'b1;
    end
    else if (w[27:26] == 2'b00)
      c[CMD_DP] = 1'b1;
    else
      c[CMD_UNDEF] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ir_fetch_decode_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface ir_fetch_decode_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ir_fetch_decode_cond.sv
// Condition evaluator: reports whether an instruction's condition field fails
// against the current NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_fail
);

  logic w_n, w_z, w_c, w_v;
  logic w_pass;

  assign {w_n, w_z, w_c, w_v} = i_nzcv;

  always_comb begin
    w_pass = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: w_pass = w_z;
      COND_NE: w_pass = ~w_z;
      COND_CS: w_pass = w_c;
      COND_CC: w_pass = ~w_c;
      COND_MI: w_pass = w_n;
      COND_PL: w_pass = ~w_n;
      COND_VS: w_pass = w_v;
      COND_VC: w_pass = ~w_v;
      COND_HI: w_pass = w_c & ~w_z;
      COND_LS: w_pass = ~w_c | w_z;
      COND_GE: w_pass = (w_n == w_v);
      COND_LT: w_pass = (w_n != w_v);
      COND_GT: w_pass = ~w_z & (w_n == w_v);
      COND_LE: w_pass = w_z | (w_n != w_v);
      COND_AL: w_pass = 1'b1;
      COND_NV: w_pass = 1'b0;
      default: w_pass = 1'b0;
    endcase
  end

  assign o_fail = ~w_pass;

endmodule

// File: rtl/ir_fetch_decode.sv
// Fetch/decode stage: fetches one word per write_ir request over a req/ack bus,
// latches it into the IR together with its decoded command and fields.
module ir_fetch_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_ir,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [3:0]               nzcv,
  ir_fetch_decode_if.master        imem,
  output logic                     W_IR_valid,
  output logic                     fetch_err,
  output logic [CMD_W-1:0]         command,
  output logic [31:0]              ir,
  output logic                     rm_imm_s,
  output logic [1:0]               rs_imm_s,
  output logic [2:0]               SHIFT_OP,
  output logic [3:0]               ALU_OP,
  output logic                     S,
  output logic                     P,
  output logic                     U,
  output logic                     W,
  output logic [1:0]               v_type,
  output logic                     TTCC
);

  fetch_state_e      r_state, w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_ir;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_fetch_err;
  logic              r_rm_imm_s, r_s, r_p, r_u, r_w;
  logic [1:0]        r_rs_imm_s, r_v_type;
  logic [2:0]        r_shift_op;
  logic [3:0]        r_alu_op;

  logic              w_timeout;
  logic              w_load;
  logic [CMD_W-1:0]  w_cmd;
  logic [31:0]       w_word;

  assign w_word    = imem.imem_rdata;
  assign w_cmd     = decode_cmd(w_word);
  assign w_load    = (r_state == FS_REQ) && imem.imem_ack;
  // The counter holds the number of ack-less REQ cycles already spent.
  assign w_timeout = (r_state == FS_REQ) && !imem.imem_ack && (r_cnt == 4'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      FS_IDLE:  if (write_ir) w_next = FS_REQ;
      FS_REQ: begin
        if (imem.imem_ack)  w_next = FS_VALID;
        else if (w_timeout) w_next = FS_IDLE;
      end
      FS_VALID: w_next = FS_IDLE;
      default:  w_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FS_IDLE;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_next;
      r_fetch_err <= w_timeout;
      if (r_state == FS_REQ && !imem.imem_ack && !w_timeout)
        r_cnt <= r_cnt + 4'd1;
      else
        r_cnt <= '0;
      if (r_state == FS_IDLE && write_ir)
        r_addr <= pc;
    end
  end

  // IR and its decode are written together so they can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= NOP_INSTR;
      r_cmd      <= CMD_W'(1) << CMD_DP;
      r_rm_imm_s <= 1'b0;
      r_rs_imm_s <= '0;
      r_shift_op <= '0;
      r_alu_op   <= '0;
      r_s        <= 1'b0;
      r_p        <= 1'b0;
      r_u        <= 1'b0;
      r_w        <= 1'b0;
      r_v_type   <= '0;
    end else if (w_load) begin
      r_ir       <= w_word;
      r_cmd      <= w_cmd;
      r_rm_imm_s <= w_cmd[CMD_DP] & ~w_word[25];
      r_rs_imm_s <= w_cmd[CMD_DP] ? {w_word[25], w_word[4]} : 2'b00;
      r_shift_op <= w_word[6:4];
      r_alu_op   <= w_word[24:21];
      r_s        <= w_word[20];
      r_p        <= w_word[24];
      r_u        <= w_word[23];
      r_w        <= w_word[21];
      r_v_type   <= w_word[6:5];
    end
  end

  cond_check u_cond (
    .i_cond (r_ir[31:28]),
    .i_nzcv (nzcv),
    .o_fail (TTCC)
  );

  assign imem.imem_req  = (r_state == FS_REQ);
  assign imem.imem_addr = r_addr;
  assign W_IR_valid     = (r_state == FS_VALID);
  assign fetch_err      = r_fetch_err;
  assign command        = r_cmd;
  assign ir             = r_ir;
  assign rm_imm_s       = r_rm_imm_s;
  assign rs_imm_s       = r_rs_imm_s;
  assign SHIFT_OP       = r_shift_op;
  assign ALU_OP         = r_alu_op;
  assign S              = r_s;
  assign P              = r_p;
  assign U              = r_u;
  assign W              = r_w;
  assign v_type         = r_v_type;

endmodule

// File: tb/tb_ir_fetch_decode.sv
// Directed bench for ir_fetch_decode: scoreboarded fetches, timeout/retry,
// reset abort, stray ack and a full condition-code sweep through the top.
module tb_ir_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_ir = 1'b0;
  logic [31:0] pc = '0;
  logic [3:0]  nzcv = '0;
  logic        W_IR_valid, fetch_err, rm_imm_s, S, P, U, W, TTCC;
  logic [63:0] command;
  logic [31:0] ir;
  logic [1:0]  rs_imm_s, v_type;
  logic [2:0]  SHIFT_OP;
  logic [3:0]  ALU_OP;

  ir_fetch_decode_if #(.ADDR_W(32)) imem ();

  ir_fetch_decode #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .write_ir(write_ir), .pc(pc), .nzcv(nzcv),
    .imem(imem), .W_IR_valid(W_IR_valid), .fetch_err(fetch_err),
    .command(command), .ir(ir), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s),
    .SHIFT_OP(SHIFT_OP), .ALU_OP(ALU_OP), .S(S), .P(P), .U(U), .W(W),
    .v_type(v_type), .TTCC(TTCC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_fail(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b1;
    return ~(c[0] ? ~base : base);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] word,
                          input int dly, input int idx);
    exp_t e;
    int   n;
    e.ir  = word;
    e.cmd = 64'd1 << idx;
    sb.push_back(e);
    pc = a;
    write_ir = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!imem.imem_req && n < 8);
    chk("req_rise", {63'd0, imem.imem_req}, 64'd1);
    chk("imem_addr", {32'd0, imem.imem_addr}, {32'd0, a});
    repeat (dly) tick();
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    tick();
    imem.imem_ack = 1'b0;
    write_ir = 1'b0;
    chk("valid_after_ack", {63'd0, W_IR_valid}, 64'd1);
    if (W_IR_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ir", {32'd0, ir}, {32'd0, e.ir});
      chk("command", command, e.cmd);
    end
    tick();
    chk("valid_one_cycle", {63'd0, W_IR_valid}, 64'd0);
  endtask

  initial begin
    int n, nv;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {63'd0, imem.imem_req}, 64'd0);
    chk("rst_valid", {63'd0, W_IR_valid}, 64'd0);
    chk("rst_ferr", {63'd0, fetch_err}, 64'd0);
    chk("rst_ir", {32'd0, ir}, 64'hE1A00000);
    chk("rst_cmd", command, 64'd1);
    chk("rst_fields", {49'd0, rm_imm_s, rs_imm_s, SHIFT_OP, ALU_OP, S, P, U, W, v_type}, 64'd0);
    chk("rst_ttcc", {63'd0, TTCC}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_fetch(32'h100, 32'hE2811001, 2, 0);
    chk("add_alu_op", {60'd0, ALU_OP}, 64'd4);
    chk("add_ttcc", {63'd0, TTCC}, 64'd0);
    chk("add_rm_imm_s", {63'd0, rm_imm_s}, 64'd0);
    chk("add_rs_imm_s", {62'd0, rs_imm_s}, 64'd2);
    chk("add_s", {63'd0, S}, 64'd0);

    do_fetch(32'h104, 32'hEB000004, 1, 3);
    do_fetch(32'h108, 32'hE12FFF1E, 0, 1);
    do_fetch(32'h10C, 32'hE7812003, 3, 7);

    do_fetch(32'h110, 32'h05912004, 1, 4);
    chk("ldr_puw", {61'd0, P, U, W}, 64'b110);
    chk("ldr_ttcc_fail", {63'd0, TTCC}, 64'd1);
    nzcv = 4'b0100;
    #1;
    chk("ldr_ttcc_live", {63'd0, TTCC}, 64'd0);
    nzcv = 4'b0000;

    // Timeout then retry
    write_ir = 1'b1;
    pc = 32'h200;
    n = 0;
    do begin tick(); n++; end while (!imem.imem_req && n < 8);
    n = 0;
    nv = 0;
    while (imem.imem_req && n < 40) begin
      if (W_IR_valid) nv++;
      tick();
      n++;
    end
    chk("timeout_req_cycles", 64'(n), 64'd15);
    chk("timeout_ferr", {63'd0, fetch_err}, 64'd1);
    chk("timeout_no_valid", 64'(nv + int'(W_IR_valid)), 64'd0);
    tick();
    chk("retry_req", {63'd0, imem.imem_req}, 64'd1);
    chk("retry_ferr_pulse", {63'd0, fetch_err}, 64'd0);

    // Reset during REQ
    rst_n = 1'b0;
    #1;
    chk("arst_req", {63'd0, imem.imem_req}, 64'd0);
    chk("arst_ir", {32'd0, ir}, 64'hE1A00000);
    chk("arst_cmd", command, 64'd1);
    write_ir = 1'b0;
    tick();
    rst_n = 1'b1;
    nv = 0;
    repeat (4) begin tick(); if (W_IR_valid) nv++; end
    chk("arst_no_valid", 64'(nv), 64'd0);

    // Stray ack in IDLE
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hEB000004;
    tick();
    imem.imem_ack = 1'b0;
    chk("stray_ir", {32'd0, ir}, 64'hE1A00000);
    chk("stray_valid", {63'd0, W_IR_valid}, 64'd0);
    tick();
    chk("stray_valid2", {63'd0, W_IR_valid}, 64'd0);

    do_fetch(32'h300, 32'hE1023091, 1, 8);
    do_fetch(32'h304, 32'hE6000010, 0, 63);

    // Condition sweep through the IR
    for (int c = 0; c < 16; c++) begin
      do_fetch(32'h400 + 32'(c * 4), {4'(c), 28'h2811001}, 0, 0);
      for (int f = 0; f < 16; f++) begin
        nzcv = 4'(f);
        #1;
        chk($sformatf("ttcc_c%0d_f%0d", c, f), {63'd0, TTCC}, {63'd0, ref_fail(4'(c), 4'(f))});
      end
    end
    nzcv = '0;

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
